// File: rtl/state_sequencer_if.sv
// Bundle between the board keys/switches, the sequencer and the
// state-to-hex display decoder.
interface state_sequencer_if;
  logic run;
  logic step;
  logic clear;
  logic state0;
  logic state1;
  logic state2;
  logic state3;
  logic state4;
  logic state5;
  logic state6;
  logic tick_o;
  logic wrap_o;

  modport master (
    output run, step, clear,
    input  state0, state1, state2, state3, state4, state5, state6,
    input  tick_o, wrap_o
  );

  modport slave (
    input  run, step, clear,
    output state0, state1, state2, state3, state4, state5, state6,
    output tick_o, wrap_o
  );
endinterface

// File: rtl/state_sequencer.sv
// One-hot state sequencer feeding the state-to-hex display decoder.
// S0 is idle; S1..S6 loop, advancing on prescaled ticks (after a dwell)
// or on each rising edge of the step key.
module state_sequencer #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int DWELL_TICKS = 2,
  parameter int CNT_W       = 26
) (
  input logic            clk,
  input logic            rst_n,
  state_sequencer_if.slave bus
);

  localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TICK_DIV - 1);
  localparam logic [DW-1:0]    DWELL_MAX = DW'(DWELL_TICKS - 1);

  typedef enum logic [6:0] {
    S0 = 7'b0000001,
    S1 = 7'b0000010,
    S2 = 7'b0000100,
    S3 = 7'b0001000,
    S4 = 7'b0010000,
    S5 = 7'b0100000,
    S6 = 7'b1000000
  } state_t;

  // Raw vector so that a corrupted (non-one-hot) value can be held and
  // detected; the display sees a separate bank loaded only with legal codes.
  logic [6:0]       state_q;
  logic [6:0]       state_out;
  state_t           next_state;
  state_t           succ;
  logic             legal;
  logic             advance;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [DW-1:0]    dwell;
  logic [DW-1:0]    dwell_next;
  logic             step_q;
  logic             step_edge;
  logic             tick_now;
  logic             tick_q;
  logic             wrap_next;
  logic             wrap_q;

  assign step_edge = bus.step & ~step_q;
  assign tick_now  = bus.run & (count == CNT_MAX);

  // Prescaler: free-runs while enabled, restarts on clear, step or hold.
  always_comb begin
    count_next = count + CNT_W'(1);
    if (bus.clear || step_edge || !bus.run) begin
      count_next = '0;
    end else if (count == CNT_MAX) begin
      count_next = '0;
    end
  end

  // Next state, dwell and wrap: clear beats step, step beats tick.
  always_comb begin
    next_state = S0;
    succ       = S0;
    legal      = 1'b1;
    advance    = 1'b0;
    dwell_next = dwell;
    wrap_next  = 1'b0;

    case (state_q)
      S0:      succ = S1;
      S1:      succ = S2;
      S2:      succ = S3;
      S3:      succ = S4;
      S4:      succ = S5;
      S5:      succ = S6;
      S6:      succ = S1;
      default: legal = 1'b0;
    endcase

    if (!legal || bus.clear) begin
      next_state = S0;
      dwell_next = '0;
    end else begin
      if (step_edge) begin
        advance = 1'b1;
      end else if (tick_now) begin
        if (state_q == S0 || dwell == DWELL_MAX) begin
          advance = 1'b1;
        end else begin
          dwell_next = dwell + DW'(1);
        end
      end

      if (advance) begin
        next_state = succ;
        dwell_next = '0;
        wrap_next  = (state_q == S6);
      end else begin
        next_state = state_t'(state_q);
      end
    end
  end

  // State register plus the display-facing copy of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S0;
      state_out <= S0;
    end else begin
      state_q   <= next_state;
      state_out <= next_state;
    end
  end

  // Prescaler, dwell, step history and pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      dwell  <= '0;
      step_q <= 1'b0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      count  <= count_next;
      dwell  <= dwell_next;
      step_q <= bus.step;
      tick_q <= tick_now;
      wrap_q <= wrap_next;
    end
  end

  assign bus.state0 = state_out[0];
  assign bus.state1 = state_out[1];
  assign bus.state2 = state_out[2];
  assign bus.state3 = state_out[3];
  assign bus.state4 = state_out[4];
  assign bus.state5 = state_out[5];
  assign bus.state6 = state_out[6];
  assign bus.tick_o = tick_q;
  assign bus.wrap_o = wrap_q;

endmodule

// File: tb/tb_state_sequencer.sv
// Bench for state_sequencer: directed scenarios plus a random phase, all
// compared every cycle against a position/count model of the sequence.
module tb_state_sequencer;

  localparam int TD = 4;
  localparam int DT = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  state_sequencer_if bus();

  state_sequencer #(
    .TICK_DIV    (TD),
    .DWELL_TICKS (DT),
    .CNT_W       (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: position in the sequence (0 = idle), ticks spent there,
  // cycles since the prescaler restarted, previous step level.
  int m_idx   = 0;
  int m_dwell = 0;
  int m_cnt   = 0;
  bit m_stepq = 1'b0;
  bit m_tick  = 1'b0;
  bit m_wrap  = 1'b0;
  bit m_inj   = 1'b0;

  function automatic logic [6:0] dutVec();
    return {bus.state6, bus.state5, bus.state4, bus.state3,
            bus.state2, bus.state1, bus.state0};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit c);
    @(negedge clk);
    bus.run   = r;
    bus.step  = s;
    bus.clear = c;
  endtask

  // Reference model: advance the sequence position from the rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idx = 0; m_dwell = 0; m_cnt = 0; m_stepq = 0;
      m_tick = 0; m_wrap = 0; m_inj = 0;
    end else begin
      bit edge_s, tick_d, adv;
      edge_s = bus.step && !m_stepq;
      tick_d = bus.run && (m_cnt == TD - 1);
      adv    = 0;
      m_wrap = 0;
      if (m_inj) begin
        m_idx = 0; m_dwell = 0; m_inj = 0;
      end else if (bus.clear) begin
        m_idx = 0; m_dwell = 0;
      end else if (edge_s) begin
        adv = 1;
      end else if (tick_d) begin
        if (m_idx == 0 || m_dwell == DT - 1) adv = 1;
        else m_dwell++;
      end
      if (adv) begin
        m_wrap  = (m_idx == 6);
        m_idx   = (m_idx == 6) ? 1 : m_idx + 1;
        m_dwell = 0;
      end
      if (bus.clear || edge_s || !bus.run) m_cnt = 0;
      else m_cnt = (m_cnt + 1) % TD;
      m_tick  = tick_d;
      m_stepq = bus.step;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [6:0] ev;
    ev = 7'd1 << m_idx;
    checkOutput("state_vec", 32'(dutVec()), 32'(ev));
    checkOutput("tick_o", 32'(bus.tick_o), 32'(m_tick));
    checkOutput("wrap_o", 32'(bus.wrap_o), 32'(m_wrap));
    checkOutput("onehot", 32'($onehot(dutVec())), 32'd1);
  end

  initial begin
    #200000;
    bad++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int first_s1, first_wrap, wraps, s0_after, ticks, k;
    bus.run = 0; bus.step = 0; bus.clear = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset_vec", 32'(dutVec()), 32'h01);
    checkOutput("reset_tick", 32'(bus.tick_o), 32'd0);
    checkOutput("reset_wrap", 32'(bus.wrap_o), 32'd0);

    // Free-running sequence.
    @(negedge clk);
    rst_n = 1; bus.run = 1;
    first_s1 = -1; first_wrap = -1; wraps = 0; s0_after = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (bus.state1 && first_s1 < 0) first_s1 = i;
      if (bus.wrap_o) begin
        wraps++;
        if (first_wrap < 0) first_wrap = i;
      end
      if (first_s1 >= 0 && bus.state0) s0_after++;
    end
    checkOutput("first_s1_cycle", 32'(first_s1), 32'd4);
    checkOutput("first_wrap_cycle", 32'(first_wrap), 32'd76);
    checkOutput("wrap_count", 32'(wraps), 32'd2);
    checkOutput("s0_reassert", 32'(s0_after), 32'd0);

    // Manual stepping with run low.
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
    ticks = 0;
    for (int p = 0; p < 3; p++) begin
      repeat (5) begin applyStimulus(0, 1, 0); ticks += int'(bus.tick_o); end
      repeat (10) begin applyStimulus(0, 0, 0); ticks += int'(bus.tick_o); end
    end
    checkOutput("manual_s3", 32'(dutVec()), 32'h08);
    checkOutput("manual_ticks", 32'(ticks), 32'd0);

    // Step coincident with dwell expiry in S2.
    applyStimulus(0, 0, 1);
    for (int p = 0; p < 2; p++) begin
      repeat (3) applyStimulus(0, 1, 0);
      repeat (3) applyStimulus(0, 0, 0);
    end
    checkOutput("pre_s2", 32'(dutVec()), 32'h04);
    applyStimulus(1, 0, 0);
    repeat (10) applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 0);
    @(negedge clk);
    checkOutput("coincide_s3", 32'(dutVec()), 32'h08);
    k = 0;
    while (!bus.state4 && k < 40) begin @(negedge clk); k++; end
    checkOutput("next_adv_gap", 32'(k), 32'd12);

    // Clear together with a step edge in S5.
    applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("pre_s5", 32'(dutVec()), 32'h20);
    applyStimulus(1, 1, 1);
    @(negedge clk);
    checkOutput("clear_s0", 32'(dutVec()), 32'h01);
    checkOutput("clear_count", 32'(dut.count), 32'd0);
    checkOutput("clear_wrap", 32'(bus.wrap_o), 32'd0);
    applyStimulus(0, 0, 0);

    // Asynchronous reset while in S4.
    repeat (4) begin
      applyStimulus(0, 1, 0);
      applyStimulus(0, 1, 0);
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
    end
    checkOutput("pre_s4", 32'(dutVec()), 32'h10);
    applyStimulus(1, 0, 0);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    checkOutput("async_vec", 32'(dutVec()), 32'h01);
    checkOutput("async_tick", 32'(bus.tick_o), 32'd0);
    checkOutput("async_wrap", 32'(bus.wrap_o), 32'd0);
    @(negedge clk);
    rst_n = 1;
    k = 0;
    while (!bus.tick_o && k < 20) begin @(negedge clk); k++; end
    checkOutput("first_tick_delay", 32'(k), 32'd4);

    // Corrupt the internal state register.
    applyStimulus(1, 0, 0);
    force dut.state_q = 7'b0000011;
    m_inj = 1;
    #1 release dut.state_q;
    @(negedge clk);
    checkOutput("illegal_to_s0", 32'(dutVec()), 32'h01);

    // Random phase.
    for (int i = 0; i < 400; i++) begin
      bit r, s, c;
      r = ($urandom_range(0, 7) != 0);
      s = ($urandom_range(0, 3) == 0) ? ~bus.step : bus.step;
      c = ($urandom_range(0, 39) == 0);
      applyStimulus(r, s, c);
    end
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
